conv_out_streamer: RTL and testbench
====================================

# conv_out_streamer

Drain side of the `conv` engine. On each rising edge of `conv`'s `out_valid`, it snapshots the full `OUT2_H x OUT2_W` signed 24-bit `out_buff` into local registers. It then serialises the snapshot row-major over a valid/ready stream, saturated to `OUT_DW` bits, toward the FC/readout stage. The block decouples the parallel result array from downstream bandwidth and flags any result frame lost while a drain is in progress.

## Interface
- `OUT2_H`, 12, result rows (matches `conv`)
- `OUT2_W`, 11, result columns (matches `conv`)
- `ACC_W`, 24, width of each `out_buff` element, signed
- `OUT_DW`, 16, stream data width, signed, `OUT_DW <= ACC_W`
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `conv_valid`  in  1  `conv` `out_valid` level; frame available on its rising edge
- `conv_buff`  in  `[OUT2_H][OUT2_W]` x `ACC_W`  `conv` `out_buff`, signed; sampled only on the capture edge
- `m_valid`  out  1  stream beat valid
- `m_ready`  in  1  downstream accepts the beat
- `m_data`  out  `OUT_DW`  saturated element, signed
- `m_sat`  out  1  current beat was clipped
- `m_last`  out  1  final element (`OUT2_H-1`, `OUT2_W-1`) of the frame
- `busy`  out  1  high from capture until the last handshake
- `done`  out  1  one-cycle pulse after the last handshake
- `overrun`  out  1  sticky; a frame edge arrived while busy
- `clr_overrun`  in  1  synchronous clear of `overrun`

## Operation
- Rising-edge detect: register `prev_v <= conv_valid`. An edge is `conv_valid & ~prev_v`.
- States are `IDLE` and `SEND`.
- `IDLE`:
  - On an edge, copy `conv_buff` into `snap`, set `row = 0`, `col = 0`, and go to `SEND`.
  - With no edge, hold.
- `SEND`:
  - `m_valid = 1`.
  - `m_data` / `m_sat` are `sat(snap[row][col])`.
  - `m_last = (row == OUT2_H-1) && (col == OUT2_W-1)`.
- Handshake is `m_valid & m_ready`. On a handshake:
  - Increment `col`; on reaching `OUT2_W`, wrap `col` to 0 and increment `row`.
  - On a handshake with `m_last`, go to `IDLE` and pulse `done`.
- Stall rule: while `m_valid & ~m_ready`, `m_data`, `m_sat`, `m_last` and the indices stay stable.
- Edge while in `SEND`, including the cycle of the final handshake: the frame is ignored, `snap` is unchanged, and `overrun` is set.
- `overrun` priority: set wins over `clr_overrun` in the same cycle.
- Saturation:
  - `x > 2^(OUT_DW-1)-1` gives `2^(OUT_DW-1)-1` with `m_sat = 1`.
  - `x < -2^(OUT_DW-1)` gives `-2^(OUT_DW-1)` with `m_sat = 1`.
  - Otherwise `x[OUT_DW-1:0]` with `m_sat = 0`.
- `busy = (state == SEND)`.
- Reset values:
  - `state = IDLE`, `prev_v = 0`, `row = 0`, `col = 0`, `snap = 0`.
  - `m_valid = 0`, `m_last = 0`, `m_sat = 0`, `m_data = 0`, `busy = 0`, `done = 0`, `overrun = 0`.
- Reset during `SEND` aborts the frame without a `done` pulse. Because `prev_v` resets to 0, a `conv_valid` still high after reset release is treated as a new edge and captured.

## Timing
- Capture latency: edge sampled at clock edge `t` gives `m_valid = 1` in the cycle after `t`. The first beat is `snap[0][0]`.
- Throughput is 1 beat/cycle with `m_ready` held high. A frame takes `OUT2_H*OUT2_W` (132) cycles from first `m_valid` to last handshake.
- `done` is high for exactly the cycle after the last handshake. In that same cycle `busy = 0` and `m_valid = 0`.
- The earliest next capture is an edge sampled in the cycle `done` is high.
- No combinational path from `m_ready` to `m_valid`, `m_data`, `m_sat` or `m_last`. These are functions of registered state only; `m_data` may be a mux of `snap` by the registered indices.
- `conv_buff` is sampled only at the capture edge; changes at any other time have no effect.

## Structure
- `conv_pkg` (shared with `conv`) holds:
  - the `OUT2_H`, `OUT2_W` and `ACC_W` constants;
  - the `stream_state_t` enum (`IDLE`, `SEND`).
- Sub-module `sat_clip #(IN_W, OUT_W)` (combinational) produces `data` and `sat`. It is reused wherever downstream narrows accumulators.
- The top block holds the edge detector, FSM, index counters, snapshot array and `overrun` logic.

## Test plan
- **Single frame, no backpressure:** `conv_buff[r][c] = r*100 + c`, then a 1-cycle `conv_valid` pulse with `m_ready = 1`.
  - Expect 132 beats in order `0, 1, …, 10, 100, …, 1110`.
  - `m_last` is high only on 1110, `done` pulses the next cycle, and `m_sat = 0` throughout.
- **Saturation:** elements `32767`, `32768`, `-32768`, `-32769`, `8388607`.
  - Expect `m_data` = `32767`, `32767`, `-32768`, `-32768`, `32767`.
  - Expect `m_sat` = `0`, `1`, `0`, `1`, `1`.
- **Random backpressure:** `m_ready` random at 30% high.
  - `m_data` is stable across every stall and the sequence is identical to scenario 1.
  - `conv_buff` is changed after capture, and the stream still shows the captured values.
- **Overrun:** second `conv_valid` edge at beat 50, plus one coinciding with the final handshake.
  - `overrun = 1` and the stream is unchanged.
  - `clr_overrun` together with a new edge in `SEND` leaves `overrun = 1`.
- **Reset mid-stream:** assert `rst` at beat 70 with `conv_valid` held high.
  - All outputs go to their reset values immediately, with no `done` pulse.
  - After release, a new capture occurs and the stream restarts at `[0][0]`.
- **Level-held `conv_valid`:** `conv_valid` held high for 300 cycles.
  - Exactly one frame is captured and `overrun` stays 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Constants and types shared by the conv engine and its drain-side streamer.
package conv_pkg;
    localparam int OUT2_H = 12;
    localparam int OUT2_W = 11;
    localparam int ACC_W  = 24;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } stream_state_t;
endpackage

// File: rtl/conv_out_streamer_if.sv
// Valid/ready result stream carrying saturated conv elements toward the readout stage.
interface conv_out_streamer_if #(parameter int DW = 16) ();
    logic                 m_valid;
    logic                 m_ready;
    logic signed [DW-1:0] m_data;
    logic                 m_sat;
    logic                 m_last;

    modport master (output m_valid, m_data, m_sat, m_last, input m_ready);
    modport slave  (input m_valid, m_data, m_sat, m_last, output m_ready);
endinterface

// File: rtl/sat_clip.sv
// Signed saturating narrowing from IN_W to OUT_W bits; flags any clipped value.
module sat_clip #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] data,
    output logic                    sat
);
    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

    always_comb begin
        data = din[OUT_W-1:0];
        sat  = 1'b0;
        if (din > MAX_V) begin
            data = MAX_V[OUT_W-1:0];
            sat  = 1'b1;
        end else if (din < MIN_V) begin
            data = MIN_V[OUT_W-1:0];
            sat  = 1'b1;
        end
    end
endmodule

// File: rtl/conv_out_streamer.sv
// Snapshots the conv result array on each out_valid rising edge and streams it
// row-major, saturated to OUT_DW bits; flags frames that arrive mid-drain.
module conv_out_streamer
    import conv_pkg::*;
#(
    parameter int OUT_DW = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    conv_valid,
    input  logic [OUT2_H-1:0][OUT2_W-1:0][ACC_W-1:0] conv_buff,
    conv_out_streamer_if.master                     m,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    overrun,
    input  logic                                    clr_overrun
);
    localparam int RW = $clog2(OUT2_H);
    localparam int CW = $clog2(OUT2_W);
    localparam logic [RW-1:0] ROW_LAST = RW'(OUT2_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(OUT2_W - 1);

    stream_state_t state_q, state_d;
    logic          prev_v_q, prev_v_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          overrun_q, overrun_d;
    logic          done_q, done_d;
    logic [OUT2_H-1:0][OUT2_W-1:0][ACC_W-1:0] snap_q, snap_d;

    logic                     frame_edge, sending, at_last, hs;
    logic signed [OUT_DW-1:0] sat_data;
    logic                     sat_flag;

    assign frame_edge = conv_valid & ~prev_v_q;
    assign sending    = (state_q == SEND);
    assign at_last    = sending && (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign hs         = sending & m.m_ready;

    sat_clip #(.IN_W(ACC_W), .OUT_W(OUT_DW)) u_sat (
        .din  (snap_q[row_q][col_q]),
        .data (sat_data),
        .sat  (sat_flag)
    );

    // Outputs depend only on registered state; gated so IDLE shows reset values.
    assign m.m_valid = sending;
    assign m.m_data  = sending ? sat_data : '0;
    assign m.m_sat   = sending & sat_flag;
    assign m.m_last  = at_last;
    assign busy      = sending;
    assign done      = done_q;
    assign overrun   = overrun_q;

    always_comb begin
        state_d   = state_q;
        prev_v_d  = conv_valid;
        row_d     = row_q;
        col_d     = col_q;
        snap_d    = snap_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        if (clr_overrun) overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_edge) begin
                    snap_d  = conv_buff;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // A frame landing mid-drain is dropped; set beats clear.
                if (frame_edge) overrun_d = 1'b1;
                if (hs) begin
                    if (at_last) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prev_v_q  <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            snap_q    <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_v_q  <= prev_v_d;
            row_q     <= row_d;
            col_q     <= col_d;
            snap_q    <= snap_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end
endmodule

// File: tb/tb_conv_out_streamer.sv
// Directed bench for conv_out_streamer: ordering, saturation, backpressure,
// overrun, mid-stream reset and level-held frame valid.
module tb_conv_out_streamer;
    import conv_pkg::*;

    localparam int N = OUT2_H * OUT2_W;

    logic clk = 1'b0;
    logic rst, conv_valid, clr_overrun;
    logic busy, done, overrun;
    logic [OUT2_H-1:0][OUT2_W-1:0][ACC_W-1:0] tb_buff;

    conv_out_streamer_if #(.DW(16)) mif ();

    conv_out_streamer #(.OUT_DW(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .conv_valid  (conv_valid),
        .conv_buff   (tb_buff),
        .m           (mif),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_v [OUT2_H][OUT2_W];

    int got_d [$];
    bit got_s [$];
    bit got_l [$];
    int stall_err, done_ok, done_bad, n_cyc;

    task automatic load(input int base);
        for (int r = 0; r < OUT2_H; r++)
            for (int c = 0; c < OUT2_W; c++) begin
                exp_v[r][c] = base + r*100 + c;
                tb_buff[r][c] = 24'(exp_v[r][c]);
            end
    endtask

    task automatic scramble_buff();
        for (int r = 0; r < OUT2_H; r++)
            for (int c = 0; c < OUT2_W; c++)
                tb_buff[r][c] = 24'(5000 + r*7 + c);
    endtask

    // One-cycle conv_valid pulse; leaves the bench at the negedge where beat 0 is visible.
    task automatic pulse_frame();
        @(negedge clk);
        mif.m_ready = 1'b0;
        conv_valid  = 1'b1;
        @(negedge clk);
        conv_valid  = 1'b0;
    endtask

    // Drains one frame, recording beats; optional extra frame edges at beat edge_beat / final beat.
    task automatic collect(input int pct, input int edge_beat, input bit edge_last, input bit clr_with_edge);
        bit stalled, last_hs, fin;
        int pd;
        bit pl, ps;
        got_d.delete(); got_s.delete(); got_l.delete();
        stall_err = 0; done_ok = 0; done_bad = 0; n_cyc = 0;
        stalled = 0; last_hs = 0; fin = 0; pd = 0; pl = 0; ps = 0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge clk);
            conv_valid  = 1'b0;
            clr_overrun = 1'b0;
            if (last_hs) begin
                done_ok = (done === 1'b1 && busy === 1'b0 && mif.m_valid === 1'b0);
                mif.m_ready = 1'b0;
                fin = 1;
            end else begin
                if (done) done_bad++;
                mif.m_ready = ($urandom_range(99) < pct);
                if (mif.m_valid) begin
                    n_cyc++;
                    if (stalled && (int'(mif.m_data) != pd || mif.m_last != pl || mif.m_sat != ps))
                        stall_err++;
                    if (mif.m_ready) begin
                        if (got_d.size() == edge_beat) begin
                            conv_valid  = 1'b1;
                            clr_overrun = clr_with_edge;
                        end
                        if (mif.m_last && edge_last) conv_valid = 1'b1;
                        got_d.push_back(int'(mif.m_data));
                        got_s.push_back(mif.m_sat);
                        got_l.push_back(mif.m_last);
                        last_hs = mif.m_last;
                        stalled = 0;
                    end else begin
                        stalled = 1;
                        pd = int'(mif.m_data); pl = mif.m_last; ps = mif.m_sat;
                    end
                end else if (stalled) begin
                    stall_err++;
                end
            end
        end
        mif.m_ready = 1'b0;
        conv_valid  = 1'b0;
    endtask

    function automatic int seq_bad();
        int bad = 0;
        for (int i = 0; i < got_d.size() && i < N; i++) begin
            if (got_d[i] != exp_v[i / OUT2_W][i % OUT2_W]) bad++;
            if (got_l[i] != (i == N-1)) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        rst = 1'b1; conv_valid = 1'b0; clr_overrun = 1'b0; mif.m_ready = 1'b0;
        load(0);
        repeat (2) @(negedge clk);
        checks++;
        if ({mif.m_valid, mif.m_last, mif.m_sat, busy, done, overrun} !== 6'b0 || mif.m_data !== 16'sd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b l=%b s=%b b=%b d=%b o=%b data=%0d expected all 0",
                     mif.m_valid, mif.m_last, mif.m_sat, busy, done, overrun, mif.m_data);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mif.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b valid=%b expected 0 0", busy, mif.m_valid);
        end
    endtask

    task automatic test_single_frame();
        int bad;
        load(0);
        pulse_frame();
        checks++;
        if (mif.m_valid !== 1'b1 || busy !== 1'b1 || mif.m_data !== 16'sd0) begin
            errors++;
            $display("FAIL capture_latency: got valid=%b busy=%b data=%0d expected 1 1 0", mif.m_valid, busy, mif.m_data);
        end
        collect(100, -1, 0, 0);
        checks++;
        if (got_d.size() != N || n_cyc != N) begin
            errors++;
            $display("FAIL frame_len: got beats=%0d cycles=%0d expected %0d", got_d.size(), n_cyc, N);
        end
        bad = seq_bad();
        checks++;
        if (bad != 0) begin errors++; $display("FAIL frame_order: got %0d bad beats expected 0", bad); end
        bad = 0;
        foreach (got_s[i]) if (got_s[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL frame_sat: got %0d sat beats expected 0", bad); end
        checks++;
        if (done_ok != 1 || done_bad != 0) begin
            errors++;
            $display("FAIL frame_done: got done_ok=%0d stray=%0d expected 1 0", done_ok, done_bad);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_width: got %b expected 0", done); end
    endtask

    task automatic test_saturation();
        int in_v  [5] = '{32767, 32768, -32768, -32769, 8388607};
        int exp_d [5] = '{32767, 32767, -32768, -32768, 32767};
        bit exp_s [5] = '{0, 1, 0, 1, 1};
        int bad = 0;
        for (int r = 0; r < OUT2_H; r++)
            for (int c = 0; c < OUT2_W; c++) tb_buff[r][c] = '0;
        for (int i = 0; i < 5; i++) tb_buff[0][i] = 24'(in_v[i]);
        pulse_frame();
        collect(100, -1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got_d.size() <= i || got_d[i] != exp_d[i] || got_s[i] != exp_s[i]) begin
                errors++;
                $display("FAIL sat_elem%0d: got data=%0d sat=%0d expected %0d %0d", i,
                         (got_d.size() > i) ? got_d[i] : -1, (got_s.size() > i) ? got_s[i] : 0, exp_d[i], exp_s[i]);
            end
        end
        for (int i = 5; i < got_d.size(); i++) if (got_d[i] != 0 || got_s[i]) bad++;
        checks++;
        if (bad != 0 || got_d.size() != N) begin
            errors++;
            $display("FAIL sat_rest: got %0d bad of %0d beats expected 0 of %0d", bad, got_d.size(), N);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        load(0);
        pulse_frame();
        scramble_buff();
        collect(30, -1, 0, 0);
        bad = seq_bad();
        checks++;
        if (bad != 0 || got_d.size() != N) begin
            errors++;
            $display("FAIL bp_order: got %0d bad, %0d beats expected 0, %0d", bad, got_d.size(), N);
        end
        checks++;
        if (stall_err != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d unstable stalls expected 0", stall_err); end
        checks++;
        if (done_ok != 1) begin errors++; $display("FAIL bp_done: got %0d expected 1", done_ok); end
    endtask

    task automatic test_overrun();
        int bad;
        load(0);
        pulse_frame();
        scramble_buff();
        collect(100, 50, 1, 1);
        bad = seq_bad();
        checks++;
        if (bad != 0 || got_d.size() != N) begin
            errors++;
            $display("FAIL ovr_stream: got %0d bad, %0d beats expected 0, %0d", bad, got_d.size(), N);
        end
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_beats_clr: got %b expected 1", overrun); end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ovr_last_no_capture: got busy=%b expected 0", busy); end
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
        load(0);
        pulse_frame();
        collect(100, -1, 1, 0);
        checks++;
        if (overrun !== 1'b1 || done_ok != 1) begin
            errors++;
            $display("FAIL ovr_final_hs: got overrun=%b done_ok=%0d expected 1 1", overrun, done_ok);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ovr_final_no_capture: got busy=%b expected 0", busy); end
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
    endtask

    task automatic test_reset_mid();
        int beats = 0;
        int bad;
        load(0);
        pulse_frame();
        for (int c = 0; c < 300 && beats < 70; c++) begin
            @(negedge clk);
            mif.m_ready = 1'b1;
            if (mif.m_valid) beats++;
        end
        @(negedge clk);
        mif.m_ready = 1'b0;
        rst = 1'b1;
        conv_valid = 1'b1;
        #1;
        checks++;
        if ({mif.m_valid, mif.m_last, mif.m_sat, busy, done} !== 5'b0 || mif.m_data !== 16'sd0 || beats != 70) begin
            errors++;
            $display("FAIL mid_reset_outputs: got v=%b b=%b d=%b data=%0d beats=%0d expected 0 0 0 0 70",
                     mif.m_valid, busy, done, mif.m_data, beats);
        end
        load(1000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mif.m_valid !== 1'b1 || mif.m_data !== 16'sd1000) begin
            errors++;
            $display("FAIL mid_reset_recapture: got valid=%b data=%0d expected 1 1000", mif.m_valid, mif.m_data);
        end
        collect(100, -1, 0, 0);
        bad = seq_bad();
        checks++;
        if (bad != 0 || got_d.size() != N || done_ok != 1) begin
            errors++;
            $display("FAIL mid_reset_stream: got %0d bad, %0d beats, done_ok=%0d expected 0, %0d, 1",
                     bad, got_d.size(), done_ok, N);
        end
    endtask

    task automatic test_level_held();
        int hs = 0;
        int dn = 0;
        load(0);
        @(negedge clk);
        conv_valid  = 1'b1;
        mif.m_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (mif.m_valid && mif.m_ready) hs++;
            if (done) dn++;
        end
        conv_valid  = 1'b0;
        mif.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (hs != N || dn != 1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL level_held: got beats=%0d done=%0d overrun=%b expected %0d 1 0", hs, dn, overrun, N);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_saturation();
        test_backpressure();
        test_overrun();
        test_reset_mid();
        test_level_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
